// File: rtl/ps2_line_sequencer.sv
// PS/2 scancode line editor: strips F0/E0 prefixes, builds a line of ASCII
// characters (with backspace) and streams the committed line out on Enter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | editing the line buffer from incoming make codes
// DRAIN   | streaming buf[0..line_len-1] out, new make codes dropped

// Scancode set 2 make code to uppercase ASCII; 0x20 marks "no mapping".
module scan_to_ascii (
   input  logic [7:0] code,
   output logic [7:0] ascii
);

   // Letters and digits only; everything else reports 0x20
   always_comb begin
      ascii = 8'h20;
      case (code)
         8'h1C: ascii = "A";
         8'h32: ascii = "B";
         8'h21: ascii = "C";
         8'h23: ascii = "D";
         8'h24: ascii = "E";
         8'h2B: ascii = "F";
         8'h34: ascii = "G";
         8'h33: ascii = "H";
         8'h43: ascii = "I";
         8'h3B: ascii = "J";
         8'h42: ascii = "K";
         8'h4B: ascii = "L";
         8'h3A: ascii = "M";
         8'h31: ascii = "N";
         8'h44: ascii = "O";
         8'h4D: ascii = "P";
         8'h15: ascii = "Q";
         8'h2D: ascii = "R";
         8'h1B: ascii = "S";
         8'h2C: ascii = "T";
         8'h3C: ascii = "U";
         8'h2A: ascii = "V";
         8'h1D: ascii = "W";
         8'h22: ascii = "X";
         8'h35: ascii = "Y";
         8'h1A: ascii = "Z";
         8'h45: ascii = "0";
         8'h16: ascii = "1";
         8'h1E: ascii = "2";
         8'h26: ascii = "3";
         8'h25: ascii = "4";
         8'h2E: ascii = "5";
         8'h36: ascii = "6";
         8'h3D: ascii = "7";
         8'h3E: ascii = "8";
         8'h46: ascii = "9";
         default: ascii = 8'h20;
      endcase
   end

endmodule

module ps2_line_sequencer #(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          code_valid,
   input  logic [7:0]    code,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_char,
   output logic          out_last,
   output logic [LW-1:0] line_len,
   output logic          busy,
   output logic          overflow
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t        state;
   logic          brk;
   logic          ext;
   logic [IW-1:0] rd;
   logic [IW-1:0] rd_inc;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    map_char;
   logic [7:0]    append_char;
   logic          make_ok;
   logic          do_append;

   scan_to_ascii u_map (
      .code  (code),
      .ascii (map_char)
   );

   // Classify the current byte: an unprefixed make code seen while collecting
   always_comb begin
      make_ok     = code_valid && (code != 8'hE0) && (code != 8'hF0)
                    && !brk && !ext && (state == COLLECT);
      append_char = (code == 8'h29) ? 8'h20 : map_char;
      do_append   = make_ok && (code != 8'h5A) && (code != 8'h66)
                    && ((code == 8'h29) || (map_char != 8'h20));
      rd_inc      = rd + IW'(1);
   end

   // Prefix tracking, line editing and drain handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         brk       <= 1'b0;
         ext       <= 1'b0;
         line_len  <= '0;
         rd        <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_char  <= 8'h00;
         busy      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         // prefixes are tracked in both states so a break sequence split
         // across a drain boundary is still swallowed correctly
         if (code_valid) begin
            if (code == 8'hE0) begin
               ext <= 1'b1;
            end else if (code == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               brk <= 1'b0;
               ext <= 1'b0;
            end
         end

         case (state)
            COLLECT: begin
               if (make_ok && code == 8'h5A) begin
                  if (line_len != '0) begin
                     state     <= DRAIN;
                     rd        <= '0;
                     out_valid <= 1'b1;
                     out_char  <= mem[0];
                     out_last  <= (line_len == LW'(1));
                     busy      <= 1'b1;
                  end
               end else if (make_ok && code == 8'h66) begin
                  if (line_len != '0) begin
                     line_len <= line_len - LW'(1);
                  end
               end else if (do_append) begin
                  if (line_len == FULL) begin
                     overflow <= 1'b1;
                  end else begin
                     mem[line_len[IW-1:0]] <= append_char;
                     line_len              <= line_len + LW'(1);
                  end
               end
            end

            DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= COLLECT;
                     line_len  <= '0;
                     rd        <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_char  <= 8'h00;
                     busy      <= 1'b0;
                     overflow  <= 1'b0;
                  end else begin
                     rd       <= rd_inc;
                     out_char <= mem[rd_inc];
                     out_last <= (LW'(rd_inc) == (line_len - LW'(1)));
                  end
               end
            end

            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: doc/ps2_line_sequencer.md
Name: ps2_line_sequencer

Overview:
- Sits between the PS/2 byte receiver and the RSA message input path.
- Parses the raw scancode byte stream: F0 break prefix and E0 extended prefix.
- Translates make codes to ASCII through an internal scan_to_ascii instance and edits a line buffer (characters, backspace).
- On Enter, streams the completed line out with a valid/ready handshake.

Parameters:
- DEPTH, 16, line buffer capacity in characters (≥2).
- LW, $clog2(DEPTH+1), width of the length/count signals.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- code_valid  in  1  one-cycle strobe, code holds a received scancode byte
- code  in  8  scancode byte
- out_valid  out  1  out_char valid
- out_ready  in  1  downstream accepts out_char
- out_char  out  8  ASCII character of the committed line
- out_last  out  1  out_char is the final character of the line
- line_len  out  LW  characters currently held (live during COLLECT, frozen during DRAIN)
- busy  out  1  high in DRAIN
- overflow  out  1  sticky: a character was dropped because the buffer was full

Behaviour:
- Reset (rst=1 at posedge):
  - State=COLLECT; brk and ext prefix flags cleared.
  - line_len=0, rd pointer=0.
  - out_valid=0, out_last=0, out_char=0x00, busy=0, overflow=0.
  - rst mid-drain aborts the line; no further out_valid.
- Prefix parsing is active in both states and on every code_valid:
  - code==0xE0: set ext.
  - code==0xF0: set brk.
  - Any other byte is a final byte. It is classified using the current flags, then brk and ext both clear.
  - If brk or ext is set, the final byte is ignored. This covers all break codes and all extended keys, including E0 5A keypad Enter.
- Make-code actions (COLLECT only, brk=ext=0):
  - 0x5A Enter:
    - line_len==0: no-op.
    - Otherwise go to DRAIN next cycle.
  - 0x66 Backspace:
    - line_len>0: line_len decrements.
    - line_len==0: no-op.
  - 0x29 Space: append 0x20.
  - Other codes: mapped through scan_to_ascii.
    - Result ≠0x20: append it.
    - Result ==0x20 (unmapped): ignore.
  - Append with line_len==DEPTH: the character is dropped and overflow is set.
  - Append write and line_len increment are visible the cycle after code_valid (latency 1).
  - Repeated make codes (typematic) each append.
- Make codes arriving in DRAIN are silently dropped; overflow is unaffected. Prefix flags still update.
- DRAIN:
  - Entered the cycle after the Enter strobe, with rd=0.
  - out_valid=1 and out_char=buf[0] in that same first cycle.
  - out_char=buf[rd]; out_last=(rd==line_len-1).
  - out_valid stays high and out_char/out_last stay stable until out_ready=1.
  - Transfer occurs when out_valid & out_ready; rd then increments.
  - Transfer with out_last=1, on the next cycle:
    - state=COLLECT, line_len=0, rd=0, out_valid=0, out_last=0.
    - overflow clears.
  - A code_valid make in the same cycle as the final transfer is dropped. A make one cycle later is accepted.
- busy = (state==DRAIN), registered.
- out_char is 0x00 whenever out_valid=0.

Test Plan:
- Reset, then strobes 1C, F0 1C, 32, F0 32, 5A, out_ready=1:
  - Outputs "A" (out_last=0), then "B" (out_last=1).
  - busy high exactly 2 cycles; line_len returns to 0.
- Strobes 16, 1E, 66, 26, 5A:
  - Emits "1","3"; line_len observed 1,2,1,2 after each edit.
- Strobes E0 75 (up arrow), E0 F0 75, E0 5A, 0E (unmapped):
  - line_len stays 0; no out_valid.
- DEPTH=16: 17 strobes of 1C, then 5A:
  - overflow=1 after the 17th; 16 "A" chars emitted, out_last on the 16th.
  - overflow=0 after the drain.
- Line "HI" committed with out_ready held 0 for 5 cycles:
  - out_char="H" stable, out_valid high throughout.
  - A 1C strobe during the stall is dropped and not emitted later.
- Assert rst after the first character of a 3-character drain:
  - Next cycle: out_valid=0, busy=0, line_len=0, overflow=0.
  - A subsequent 1C,5A emits "A" alone.
